// File: rtl/storage_reader.sv
// Read-side companion to the A/B/C/D storage bank: snapshots all four words on START,
// then streams a 1-4 word burst over valid/ready. Optional checksum beat: STORAGE_READER_CHECKSUM_EN.
module storage_reader #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       START_SEL,
    input  logic [2:0]       COUNT,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [1:0]       DOUT_SEL,
    output logic             DOUT_LAST,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       DBG_STATE
);

    // Handshake: a beat moves on every rising edge where DOUT_VALID && DOUT_READY.
    // While VALID is high and READY low, DOUT/DOUT_SEL/DOUT_LAST stay frozen, and
    // VALID only falls after a transfer. READY is ignored when VALID is low.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_FIN  = 2'd2
`ifdef STORAGE_READER_CHECKSUM_EN
        ,
        S_CSUM = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q [4];
    logic [WIDTH-1:0] snap_d [4];
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       rem_q, rem_d;
    logic             xfer;
`ifdef STORAGE_READER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
`endif

    // Snapshot slots are indexed by the select code itself: 3=A, 2=B, 1=C, 0=D,
    // so advancing A->B->C->D->A is simply a 2-bit decrement of the pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            for (int i = 0; i < 4; i++) snap_q[i] <= '0;
`ifdef STORAGE_READER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
`ifdef STORAGE_READER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        for (int i = 0; i < 4; i++) snap_d[i] = snap_q[i];
`ifdef STORAGE_READER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    snap_d[3] = A;
                    snap_d[2] = B;
                    snap_d[1] = C;
                    snap_d[0] = D;
                    ptr_d     = START_SEL;
                    rem_d     = ((COUNT == 3'd0) || (COUNT > 3'd4)) ? 3'd4 : COUNT;
`ifdef STORAGE_READER_CHECKSUM_EN
                    sum_d     = '0;
`endif
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    rem_d = rem_q - 3'd1;
                    ptr_d = ptr_q - 2'd1;
`ifdef STORAGE_READER_CHECKSUM_EN
                    sum_d = sum_q + snap_q[ptr_q];
                    if (rem_q == 3'd1) state_d = S_CSUM;
`else
                    if (rem_q == 3'd1) state_d = S_FIN;
`endif
                end
            end
`ifdef STORAGE_READER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_d = S_FIN;
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        DOUT       = '0;
        DOUT_VALID = 1'b0;
        DOUT_SEL   = 2'b00;
        DOUT_LAST  = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        xfer       = 1'b0;
        DBG_STATE  = state_q;
        case (state_q)
            S_SEND: begin
                DOUT       = snap_q[ptr_q];
                DOUT_VALID = 1'b1;
                DOUT_SEL   = ptr_q;
                BUSY       = 1'b1;
                xfer       = DOUT_READY;
`ifndef STORAGE_READER_CHECKSUM_EN
                DOUT_LAST  = (rem_q == 3'd1);
`endif
            end
`ifdef STORAGE_READER_CHECKSUM_EN
            S_CSUM: begin
                DOUT       = sum_q;
                DOUT_VALID = 1'b1;
                DOUT_LAST  = 1'b1;
                BUSY       = 1'b1;
                xfer       = DOUT_READY;
            end
`endif
            S_FIN:   DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_storage_reader.sv
// Bench for storage_reader: directed and random bursts checked against a queue of expected beats.
module tb_storage_reader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   start_sel;
    logic [2:0]   count;
    logic [W-1:0] a_in, b_in, c_in, d_in;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [1:0]   dout_sel;
    logic         dout_last;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_sel_q[$];

    storage_reader #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .START_SEL(start_sel), .COUNT(count),
        .A(a_in), .B(b_in), .C(c_in), .D(d_in),
        .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
        .DOUT_SEL(dout_sel), .DOUT_LAST(dout_last), .BUSY(busy), .DONE(done),
        .DBG_STATE(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: the burst visits registers in the cyclic order A,B,C,D starting
    // at the selected one; effective length clamps 0 and 5-7 to 4.
    task automatic build_expected(input logic [1:0] sel, input logic [2:0] cnt,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] regs [4];
        logic [1:0]   codes [4];
        int n, first;
        logic [W-1:0] sum;
        regs[0] = a; regs[1] = b; regs[2] = c; regs[3] = d;
        codes[0] = 2'b11; codes[1] = 2'b10; codes[2] = 2'b01; codes[3] = 2'b00;
        n = (cnt >= 3'd1 && cnt <= 3'd4) ? int'(cnt) : 4;
        first = 0;
        for (int k = 0; k < 4; k++) if (codes[k] == sel) first = k;
        exp_q.delete();
        exp_sel_q.delete();
        sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(regs[(first + i) % 4]);
            exp_sel_q.push_back(codes[(first + i) % 4]);
            sum = sum + regs[(first + i) % 4];
        end
`ifdef STORAGE_READER_CHECKSUM_EN
        exp_q.push_back(sum);
        exp_sel_q.push_back(2'b00);
`endif
    endtask

    // driver: one full burst, from an IDLE negedge to the IDLE negedge after DONE
    task automatic run_burst(input logic [1:0] sel, input logic [2:0] cnt,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d,
                             input int stall, input bit rnd_ready,
                             input bit scramble, input bit poke_start);
        int cycles;
        int nbeats;
        int stalls;
        @(negedge clk);
        check("idle_valid", {31'd0, dout_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        build_expected(sel, cnt, a, b, c, d);
        nbeats = exp_q.size();
        start = 1'b1; start_sel = sel; count = cnt;
        a_in = a; b_in = b; c_in = c; d_in = d;
        dout_ready = $urandom_range(0, 1);
        @(negedge clk);
        start = 1'b0;
        check("first_valid_latency", {31'd0, dout_valid}, 32'd1);
        cycles = 0;
        stalls = stall;
        while (exp_q.size() > 0 && cycles < 64) begin
            check("valid", {31'd0, dout_valid}, 32'd1);
            check("dout", {24'd0, dout}, {24'd0, exp_q[0]});
            check("sel", {30'd0, dout_sel}, {30'd0, exp_sel_q[0]});
            check("last", {31'd0, dout_last}, {31'd0, exp_q.size() == 1});
            check("busy", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            if (stalls > 0) begin
                dout_ready = 1'b0;
                stalls--;
            end else if (rnd_ready) begin
                dout_ready = $urandom_range(0, 1);
            end else begin
                dout_ready = 1'b1;
            end
            if (scramble) begin
                a_in = W'($urandom); b_in = W'($urandom);
                c_in = W'($urandom); d_in = W'($urandom);
            end
            if (poke_start) start = $urandom_range(0, 1);
            if (dout_ready) begin
                void'(exp_q.pop_front());
                void'(exp_sel_q.pop_front());
            end
            cycles++;
            @(negedge clk);
        end
        check("burst_timeout", {31'd0, cycles >= 64}, 32'd0);
        if (stall == 0 && !rnd_ready) check("beat_cycles", cycles, nbeats);
        check("fin_done", {31'd0, done}, 32'd1);
        check("fin_busy", {31'd0, busy}, 32'd0);
        check("fin_valid", {31'd0, dout_valid}, 32'd0);
        check("fin_last", {31'd0, dout_last}, 32'd0);
        start = poke_start;
        dout_ready = $urandom_range(0, 1);
        @(negedge clk);
        start = 1'b0;
        check("post_done", {31'd0, done}, 32'd0);
        check("post_valid", {31'd0, dout_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, {24'd0, dout}, 32'd0);
        check({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_sel"}, {30'd0, dout_sel}, 32'd0);
        check({tag, "_last"}, {31'd0, dout_last}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_sel = 2'b00; count = 3'd0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_burst(2'b11, 3'd4, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0);
        run_burst(2'b01, 3'd3, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0);
        run_burst(2'b11, 3'd4, 8'h11, 8'h22, 8'h33, 8'h44, 3, 0, 1, 0);
        run_burst(2'(($urandom_range(0, 3))), 3'd0, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 0, 0, 0);
        run_burst(2'(($urandom_range(0, 3))), 3'd7, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 0, 0, 0);
        run_burst(2'b10, 3'd1, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0);
        run_burst(2'b00, 3'd4, 8'h10, 8'h20, 8'h30, 8'h40, 1, 1, 1, 1);
        run_burst(2'b11, 3'd4, 8'h80, 8'h80, 8'h01, 8'h02, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            run_burst(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a burst
        @(negedge clk);
        start = 1'b1; start_sel = 2'b11; count = 3'd4; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");
        @(negedge clk);
        check_all_zero("after_midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
